// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder and its store buffer.
// Provides the store-buffer entry layout, default sizes and the word-index range check.
// Optional feature macro used by this slice: DMEM_SB_FWD_EN (store-to-load forwarding).
package dmem_pkg;

    localparam int DMEM_DEPTH    = 512;
    localparam int DMEM_SB_DEPTH = 4;
    localparam int DMEM_IDX_W    = $clog2(DMEM_DEPTH);

    // Entries keep the full 30-bit word index so the buffer is independent of DEPTH.
    localparam int WIDX_W = 30;

    typedef struct packed {
        logic [WIDX_W-1:0] widx;
        logic [31:0]       data;
    } sb_entry_t;

    function automatic logic idx_in_range(input logic [WIDX_W-1:0] widx, input int depth);
        return {2'b00, widx} < $unsigned(depth);
    endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// In-order store buffer: circular FIFO of {word index, data} with youngest-match lookup.
// Ports: enq/enq_entry push at tail, deq pops head; full/empty/count status; head_entry;
//        lk_widx in, lk_hit/lk_data out (youngest valid entry whose index matches).
module store_buffer_fifo
    import dmem_pkg::*;
#(
    parameter int SB_DEPTH = DMEM_SB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enq,
    input  sb_entry_t              enq_entry,
    input  logic                   deq,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(SB_DEPTH):0] count,
    output sb_entry_t              head_entry,
    input  logic [WIDX_W-1:0]      lk_widx,
    output logic                   lk_hit,
    output logic [31:0]            lk_data
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t         mem [SB_DEPTH];
    logic [SB_DEPTH-1:0] vld;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              enq_ok;
    logic              deq_ok;

    assign full       = (count == CW'(SB_DEPTH));
    assign empty      = (count == '0);
    assign enq_ok     = enq && !full;
    assign deq_ok     = deq && !empty;
    assign head_entry = mem[head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (deq_ok) begin
                vld[head] <= 1'b0;
                head      <= head + 1'b1;
            end
            if (enq_ok) begin
                vld[tail] <= 1'b1;
                tail      <= tail + 1'b1;
            end
            if (enq_ok && !deq_ok) begin
                count <= count + 1'b1;
            end else if (deq_ok && !enq_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage carries no reset; validity is tracked by vld.
    always_ff @(posedge clk) begin
        if (enq_ok) begin
            mem[tail] <= enq_entry;
        end
    end

    // Walk from oldest (head) to youngest so the last hit wins.
    always_comb begin
        logic [PW-1:0] pos;
        pos     = '0;
        lk_hit  = 1'b0;
        lk_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            pos = head + PW'(i);
            if (vld[pos] && (mem[pos].widx == lk_widx)) begin
                lk_hit  = 1'b1;
                lk_data = mem[pos].data;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: posted stores via store buffer, 0-cycle loads, busy stall.
// Ports: clk, rst (async active-low), we/re/addr/wdata from the core, rdata/busy back to it.
// Build option DMEM_SB_FWD_EN: forward loads from the buffer instead of stalling on a match.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH    = DMEM_DEPTH,
    parameter int SB_DEPTH = DMEM_SB_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy
);

    localparam int IW = $clog2(DEPTH);

    logic [31:0]               ram [DEPTH];
    logic [WIDX_W-1:0]         widx;
    logic                      in_rng;
    logic                      is_load;
    logic                      full;
    logic                      empty;
    logic [$clog2(SB_DEPTH):0] count;
    sb_entry_t                 head_entry;
    sb_entry_t                 enq_entry;
    logic                      lk_hit;
    logic [31:0]               lk_data;
    logic                      enq;
    logic                      drain;
    logic                      hazard;
    logic                      unused_bits;

    assign widx    = addr[31:2];
    assign in_rng  = idx_in_range(widx, DEPTH);
    // we=re=1 is served as a store only.
    assign is_load = re && !we;

    assign enq_entry = '{widx: widx, data: wdata};
    assign enq       = rst && we && in_rng && !full;

`ifdef DMEM_SB_FWD_EN
    assign hazard = 1'b0;
`else
    // Without forwarding, a load hitting a pending store waits for it to drain.
    assign hazard = is_load && in_rng && lk_hit;
`endif

    assign busy = rst && ((we && full) || hazard);

    // The RAM port is free unless a non-stalled re is using it.
    assign drain = rst && (!re || busy) && !empty;

    store_buffer_fifo #(
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .enq        (enq),
        .enq_entry  (enq_entry),
        .deq        (drain),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .head_entry (head_entry),
        .lk_widx    (widx),
        .lk_hit     (lk_hit),
        .lk_data    (lk_data)
    );

    always_ff @(posedge clk) begin
        if (drain) begin
            ram[head_entry.widx[IW-1:0]] <= head_entry.data;
        end
    end

    always_comb begin
        rdata = '0;
        if (rst && is_load && in_rng) begin
`ifdef DMEM_SB_FWD_EN
            if (lk_hit) begin
                rdata = lk_data;
            end else begin
                rdata = ram[widx[IW-1:0]];
            end
`else
            rdata = ram[widx[IW-1:0]];
`endif
        end
    end

`ifdef DMEM_SB_FWD_EN
    assign unused_bits = ^{addr[1:0], head_entry.widx[WIDX_W-1:IW], count};
`else
    assign unused_bits = ^{addr[1:0], head_entry.widx[WIDX_W-1:IW], count, lk_data};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=512, SB_DEPTH=4).
// Expected values are hand-computed; forwarding-dependent stall counts follow DMEM_SB_FWD_EN.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;

    int total;
    int bad;

`ifdef DMEM_SB_FWD_EN
    localparam int FWD_STALL   = 0;
    localparam int YOUNG_STALL = 0;
`else
    localparam int FWD_STALL   = 1;
    localparam int YOUNG_STALL = 2;
`endif

    dmem_responder #(
        .DEPTH    (512),
        .SB_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .re    (re),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        we    = w;
        re    = r;
        addr  = a;
        wdata = d;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (n) tick();
    endtask

    // Plain store (re=0): the port is free, so a pending head drains this cycle.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, a, d);
        tick();
    endtask

    // Store with re also high: handled as store only and keeps the RAM port busy.
    task automatic bstore(input string tag, input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, a, d);
        check({tag, "_busy"}, {31'b0, busy}, 32'h0);
        check({tag, "_rdata"}, rdata, 32'h0);
        tick();
    endtask

    // Load, holding inputs while busy (bounded), then compare stall count and data.
    task automatic load_wait(input string tag, input logic [31:0] a, input logic [31:0] exp,
                             input int exp_stalls);
        int n;
        n = 0;
        drive(1'b0, 1'b1, a, 32'h0);
        while (busy && n < 16) begin
            tick();
            #1;
            n++;
        end
        check({tag, "_stalls"}, n, exp_stalls);
        check(tag, rdata, exp);
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(1'b0, 1'b1, 32'h10, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_busy_ld", {31'b0, busy}, 32'h0);
        drive(1'b1, 1'b0, 32'h10, 32'h1);
        check("rst_busy_st", {31'b0, busy}, 32'h0);
        tick();
        rst = 1'b1;

        // Known RAM contents for later comparisons.
        store(32'h10, 32'h100);
        store(32'h14, 32'h200);
        store(32'h00, 32'h77);
        idle(4);
        load_wait("init_10", 32'h10, 32'h100, 0);

        // Reset with two un-drained stores pending.
        bstore("rd_a", 32'h10, 32'h11);
        bstore("rd_b", 32'h14, 32'h22);
        rst = 1'b0;
        drive(1'b0, 1'b1, 32'h10, 32'h0);
        check("rd_in_rst_rdata", rdata, 32'h0);
        check("rd_in_rst_busy", {31'b0, busy}, 32'h0);
        tick();
        rst = 1'b1;
        load_wait("rd_post_10", 32'h10, 32'h100, 0);
        load_wait("rd_post_14", 32'h14, 32'h200, 0);
        idle(3);
        load_wait("rd_late_10", 32'h10, 32'h100, 0);

        // Store then load next cycle.
        store(32'h40, 32'hDEADBEEF);
        load_wait("fwd", 32'h40, 32'hDEADBEEF, FWD_STALL);

        // Youngest match; an unrelated load must not stall.
        bstore("yg_1", 32'h80, 32'h1);
        bstore("yg_2", 32'h80, 32'h2);
        drive(1'b0, 1'b1, 32'h84, 32'h0);
        check("yg_unrel_busy", {31'b0, busy}, 32'h0);
        tick();
        load_wait("young", 32'h80, 32'h2, YOUNG_STALL);
        idle(3);
        load_wait("young_ram", 32'h80, 32'h2, 0);

        // Full buffer: four held stores, fifth stalls exactly one cycle.
        for (int i = 0; i < 4; i++) begin
            bstore("full_fill", 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        end
        drive(1'b1, 1'b0, 32'h110, 32'hA4);
        check("full_busy_n", {31'b0, busy}, 32'h1);
        tick();
        check("full_busy_n1", {31'b0, busy}, 32'h0);
        tick();
        idle(6);
        for (int i = 0; i < 5; i++) begin
            load_wait("full_rd", 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 0);
        end

        // Out-of-range store is not enqueued: four more fit before the buffer is full.
        bstore("oor_st", 32'h800, 32'h5);
        for (int i = 0; i < 4; i++) begin
            bstore("oor_fill", 32'h200 + 32'(4 * i), 32'hC0 + 32'(i));
        end
        drive(1'b1, 1'b1, 32'h210, 32'hC4);
        check("oor_full_busy", {31'b0, busy}, 32'h1);
        tick();
        check("oor_full_busy2", {31'b0, busy}, 32'h0);
        tick();
        idle(6);
        load_wait("oor_ld", 32'h800, 32'h0, 0);
        load_wait("oor_wrap0", 32'h0, 32'h77, 0);
        load_wait("oor_c0", 32'h200, 32'hC0, 0);
        load_wait("oor_c4", 32'h210, 32'hC4, 0);

        // Drain ordering to the same word.
        bstore("ord_a", 32'h20, 32'hA);
        bstore("ord_b", 32'h20, 32'hB);
        idle(4);
        load_wait("ord", 32'h20, 32'hB, 0);

        drive(1'b0, 1'b0, 32'h20, 32'h0);
        check("noload_rdata", rdata, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core. It is the memory-side end of the MEM-stage bus (`we`, `re`, `addr`, `wdata`, `rdata`). Stores are posted into a small in-order store buffer that drains into a single-ported word RAM on idle cycles. Loads return data combinationally in the same cycle, with forwarding from pending stores, and a `busy` stall request covers the cases the buffer cannot absorb.

## Interface
Parameters:
- `DEPTH`, 512: RAM depth in 32-bit words; power of two.
- `SB_DEPTH`, 4: store-buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `we`  in  1  store request (MEM stage).
- `re`  in  1  load request (MEM stage).
- `addr`  in  32  byte address; word index = `addr[31:2]`, `addr[1:0]` ignored.
- `wdata`  in  32  store data.
- `rdata`  out  32  load data, combinational.
- `busy`  out  1  stall request, combinational; the core holds MEM-stage inputs while it is high.

## Operation
- **In range.** An access is in range iff `addr[31:2] < DEPTH`.
  - Out-of-range stores are dropped and never enqueued.
  - Out-of-range loads return 0.
- **Store buffer.** Circular FIFO of {word index, data} with head/tail pointers and a count of 0..SB_DEPTH.
- **Store accept.** The store is enqueued at the tail when `we`=1, it is in range, and the buffer is not full.
- **Store while full.** If `we`=1 and the buffer is full, `busy`=1 and the store is not accepted.
- **Drain.** When the RAM port is free and count>0, the head entry is written to the RAM and head advances. The port is free when `re`=0, or when the current load is stalled (`busy`=1).
- **Simultaneous enqueue and drain.** Both happen in the same cycle; count is unchanged.
- **Load.**
  - With forwarding, `rdata` is the youngest buffer entry whose index matches.
  - Otherwise `rdata` is RAM[index].
  - When `re`=0, `rdata`=0.
- **`we`=`re`=1.** Illegal from the core. It is handled as a store only, and `rdata`=0.
- **Full-buffer store completes in two cycles.**
  - Cycle N: `busy`=1. The port is free because `re`=0, so the head drains.
  - Cycle N+1: `busy`=0 and the held store is enqueued.
- **Reset.** Pointers, count and `busy` are cleared, which empties the buffer. `rdata`=0 while `rst`=0. RAM contents are not reset.
- **Reset during a pending drain.** Un-drained stores are discarded.

## Timing
- Load latency is 0 cycles: `rdata` is valid in the same cycle as `re`.
- A store is visible to a load in the cycle after acceptance, through the buffer.
- A store reaches the RAM at least 1 cycle after acceptance, at the first free port cycle.
- `busy` depends only on `we`, `re`, `addr`, count and buffer contents. It has no registered delay.
- Worst case, a stream of back-to-back loads starves the drain. Stores then stall only when the buffer is full.

## Configuration
- `DMEM_SB_FWD_EN` defined:
  - Loads forward from the youngest matching buffer entry, with priority ordered by age from tail.
  - `busy` is asserted only for a store while the buffer is full.
- `DMEM_SB_FWD_EN` undefined:
  - No forwarding comparators on the data path.
  - A load whose index matches any valid entry asserts `busy`. Drains proceed in those cycles until no entry matches, then the load completes from the RAM.
  - Store-while-full behaviour is unchanged.

## Structure
- Package `dmem_pkg`:
  - `sb_entry_t` struct {word index, data}.
  - Default `DEPTH`/`SB_DEPTH` constants.
  - Index width as `$clog2(DEPTH)`.
- Sub-module `store_buffer_fifo`:
  - Enqueue, dequeue, full/empty, count, head-entry output.
  - Associative youngest-match lookup output (match valid + data).
- The top level holds the RAM array, the range check, the drain/port arbitration and the `busy` logic.

## Test plan
- **Reset mid-drain.** Store 0x11 to 0x10 and 0x22 to 0x14, then assert `rst`=0 with both pending. Afterwards count=0, `busy`=0 and `rdata`=0; loads return the pre-store RAM values.
- **Store/load forwarding (`DMEM_SB_FWD_EN`).**
  - Store 0xDEADBEEF to 0x40, then load 0x40 next cycle: `rdata`=0xDEADBEEF same cycle and `busy`=0.
  - Without the macro: `busy`=1 for 1 cycle, then `rdata`=0xDEADBEEF from the RAM.
- **Youngest match wins.** Store 0x1 then 0x2 to 0x80 while loads block the drain; load 0x80 → `rdata`=0x2.
- **Full buffer.** Issue 4 stores with interleaved loads so none drain, then a 5th store. `busy`=1 for exactly 1 cycle; the 5th store is enqueued next cycle; all 5 values later read back correctly from the RAM.
- **Out of range.** With `DEPTH`=512, store 0x5 to 0x800 (index 512): not enqueued, count unchanged. A load from 0x800 → 0.
- **Drain ordering.** Store 0xA, then 0xB, to 0x20, then idle 4 cycles. RAM[8]=0xB, the buffer is empty, and a load from 0x20 returns 0xB from the RAM.
